bus_master_if: RTL and testbench
================================

Name: bus_master_if

Overview:
- Per-master bus interface; sits directly upstream of the shared bus (arbiter / master mux), one instance per master (CPU IF stage, CPU MEM stage, DMA).
- Converts a simple core-side access request (as_, rw, addr, wr_data) into the bus handshake: req_/grnt_ arbitration, one-cycle as_ strobe, wait for rdy_, release.
- Stalls the core via busy, returns read data, and aborts hung transactions with a timeout error.

Parameters:
ADDR_W, 30, word address width (matches WordAddrBus)
DATA_W, 32, data width (matches WordDataBus)
TIMEOUT, 255, max cycles in WAIT before abort; legal range 2..65535
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = reset)
as_  in  1  core access strobe, active-low, level; held until busy=0
rw  in  1  core direction: 1 = read, 0 = write
addr  in  ADDR_W  core word address
wr_data  in  DATA_W  core write data
stall  in  1  core pipeline stall; holds completed read result
flush  in  1  core flush; suppresses acceptance of a new access
rd_data  out  DATA_W  read data to core
busy  out  1  core must hold request and stall
bus_err  out  1  one-cycle pulse on timeout abort
bus_req_  out  1  bus request to arbiter, active-low
bus_grnt_  in  1  grant from arbiter, active-low
bus_addr  out  ADDR_W  bus address
bus_as_  out  1  bus address strobe, active-low
bus_rw  out  1  bus direction, 1 = read
bus_wr_data  out  DATA_W  bus write data
bus_rd_data  in  DATA_W  muxed slave read data
bus_rdy_  in  1  muxed slave ready, active-low

Behaviour:
- Reset (reset=0, async): state=IDLE; bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, rd_buf=0, timeout cnt=0, bus_err=0.
- States: IDLE, REQ, ACCESS, WAIT, STALL.
- IDLE:
  - Accept when as_=0 && flush=0: latch addr/rw/wr_data into bus_addr/bus_rw/bus_wr_data, bus_req_<=0, go REQ.
  - busy=1 combinationally in the accept cycle; rd_data=0.
  - flush=1 or as_=1: stay IDLE, busy=0.
- REQ: busy=1. bus_grnt_=0 -> bus_as_<=0, go ACCESS. Otherwise wait indefinitely; no timeout while ungranted.
- ACCESS:
  - bus_as_=0 for exactly this one cycle; bus_as_<=1, cnt<=0, go WAIT. busy=1.
  - A slave may assert rdy_ already in ACCESS; sample it here with the same handling as WAIT, skipping WAIT.
- WAIT: bus_addr/bus_rw/bus_wr_data held.
  - bus_rdy_=0:
    - busy=0 and rd_data=bus_rd_data (combinational pass-through) in that cycle.
    - rd_buf<=bus_rd_data; bus_req_<=1.
    - Next state STALL if stall=1, else IDLE.
    - Writes return rd_data=0.
  - bus_rdy_=1 && cnt==TIMEOUT-1: abort.
    - bus_req_<=1, bus_err<=1 (one cycle), go IDLE.
    - busy=0 in the abort cycle; rd_data=0.
  - Else cnt<=cnt+1; busy=1.
- STALL: busy=0, rd_data=rd_buf. stall=0 -> IDLE. New requests are accepted only from IDLE.
- Latency: grant on the first REQ cycle and rdy_ in the first WAIT cycle gives accept -> busy low in 4 cycles (IDLE, REQ, ACCESS, WAIT).
- Back-to-back: a new access is accepted in the IDLE cycle directly after completion; bus_req_ is deasserted for at least one cycle between transactions so the arbiter can re-arbitrate.
- Flush while in REQ/ACCESS/WAIT does not abort the bus transaction (protocol must complete); the result is still returned.
- Core changes to as_/addr after acceptance are ignored until IDLE.
- Reset mid-transaction: immediate return to reset values; bus_req_ and bus_as_ go high asynchronously.
- bus_rdy_ is ignored in IDLE, REQ and STALL.

Test Plan:
1. Read: addr=30'h0000_0100, rw=1; grant after 2 REQ cycles; rdy_ in 1st WAIT with bus_rd_data=32'hDEAD_BEEF -> bus_as_ low for exactly 1 cycle with bus_addr=30'h100; busy low in rdy_ cycle; rd_data=32'hDEAD_BEEF; bus_req_ high next cycle.
2. Write: rw=0, wr_data=32'h1234_5678; slave rdy_ after 3 WAIT cycles -> bus_rw=0 and bus_wr_data held stable for all WAIT cycles; busy=1 for 6 cycles after accept.
3. Stall hold: read returns 32'hA5A5_0001 with stall=1 for 3 cycles -> rd_data stays 32'hA5A5_0001 while in STALL; as_=0 in STALL is not accepted; accepted in the first IDLE cycle after stall=0.
4. Timeout: TIMEOUT=4, slave never ready -> after 4 WAIT cycles bus_err pulses exactly 1 cycle, busy=0, rd_data=0, bus_req_=1, state IDLE.
5. Flush/arbitration: as_=0 with flush=1 -> bus_req_ stays 1. grant withheld 50 cycles -> no bus_err, busy=1 throughout, bus_as_ high until grant.
6. Async reset: assert reset=0 mid-WAIT between clock edges -> bus_req_=1, bus_as_=1, busy=0 immediately; the next access completes normally after release.

Source files
------------

// File: rtl/bus_master_if.sv
// Per-master bus interface: turns a level-held core access into the req_/grnt_/as_/rdy_
// bus handshake, stalls the core via busy, and aborts accesses whose slave never answers.
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              bus_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    typedef enum logic [2:0] {IDLE, REQ, ACCESS, WAIT, STALL} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rd_buf;
    logic              accept, done, abort;

    // Accept is gated by reset so busy drops with the asynchronous reset even if as_ is held.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        rd_data   = '0;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (reset && !as_ && !flush) begin
                    accept    = 1'b1;
                    busy      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (!bus_grnt_) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!bus_rdy_) begin
                    done = 1'b1;
                end else begin
                    busy      = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!bus_rdy_) begin
                    done = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            STALL: begin
                rd_data = rd_buf;
                if (!stall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (done) begin
            state_nxt = stall ? STALL : IDLE;
            if (bus_rw) rd_data = bus_rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
            cnt         <= '0;
            bus_err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bus_err <= abort;
            if (accept) begin
                bus_addr    <= addr;
                bus_rw      <= rw;
                bus_wr_data <= wr_data;
                bus_req_    <= 1'b0;
            end
            if (state == REQ && !bus_grnt_) bus_as_ <= 1'b0;
            if (state == ACCESS) begin
                bus_as_ <= 1'b1;
                cnt     <= '0;
            end
            if (state == WAIT && bus_rdy_) cnt <= cnt + CNT_W'(1);
            // Dropping req_ on completion guarantees a one-cycle gap for re-arbitration.
            if (done || abort) bus_req_ <= 1'b1;
            if (done) rd_buf <= bus_rw ? bus_rd_data : '0;
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: read, write, stall hold, timeout, flush/arbitration, async reset.
module tb_bus_master_if;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              bus_err;
  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  int checks = 0;
  int errors = 0;

  bus_master_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .as_(as_), .rw(rw), .addr(addr), .wr_data(wr_data),
    .stall(stall), .flush(flush), .rd_data(rd_data), .busy(busy), .bus_err(bus_err),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;

    // Reset state
    nxt(); #1;
    chk("rst_req", bus_req_ === 1'b1, bus_req_, 1'b1);
    chk("rst_as", bus_as_ === 1'b1, bus_as_, 1'b1);
    chk("rst_rw", bus_rw === 1'b1, bus_rw, 1'b1);
    chk("rst_addr", bus_addr === 30'h0, bus_addr, 30'h0);
    chk("rst_wdata", bus_wr_data === 32'h0, bus_wr_data, 32'h0);
    chk("rst_busy", busy === 1'b0, busy, 1'b0);
    chk("rst_err", bus_err === 1'b0, bus_err, 1'b0);
    chk("rst_rdata", rd_data === 32'h0, rd_data, 32'h0);
    nxt(); reset = 1'b1;

    // 1: read, grant after two REQ cycles, ready in first WAIT
    nxt(); as_ = 1'b0; rw = 1'b1; addr = 30'h100; #1;
    chk("rd_accept_busy", busy === 1'b1, busy, 1'b1);
    nxt(); #1;
    chk("rd_req_low", bus_req_ === 1'b0, bus_req_, 1'b0);
    chk("rd_req_as_hi", bus_as_ === 1'b1, bus_as_, 1'b1);
    chk("rd_req_busy", busy === 1'b1, busy, 1'b1);
    nxt(); #1;
    chk("rd_req2_as_hi", bus_as_ === 1'b1, bus_as_, 1'b1);
    nxt(); bus_grnt_ = 1'b0; #1;
    chk("rd_req3_as_hi", bus_as_ === 1'b1, bus_as_, 1'b1);
    nxt(); bus_grnt_ = 1'b1; #1;
    chk("rd_access_as", bus_as_ === 1'b0, bus_as_, 1'b0);
    chk("rd_access_addr", bus_addr === 30'h100, bus_addr, 30'h100);
    chk("rd_access_busy", busy === 1'b1, busy, 1'b1);
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF; #1;
    chk("rd_wait_as", bus_as_ === 1'b1, bus_as_, 1'b1);
    chk("rd_done_busy", busy === 1'b0, busy, 1'b0);
    chk("rd_done_data", rd_data === 32'hDEAD_BEEF, rd_data, 32'hDEAD_BEEF);
    nxt(); as_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0; #1;
    chk("rd_after_req", bus_req_ === 1'b1, bus_req_, 1'b1);
    chk("rd_after_busy", busy === 1'b0, busy, 1'b0);
    chk("rd_after_data", rd_data === 32'h0, rd_data, 32'h0);

    // 2: write, ready after three WAIT cycles
    nxt(); as_ = 1'b0; rw = 1'b0; addr = 30'h200; wr_data = 32'h1234_5678; bus_grnt_ = 1'b0; #1;
    chk("wr_accept_busy", busy === 1'b1, busy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      nxt(); bus_rdy_ = (i == 5) ? 1'b0 : 1'b1; bus_rd_data = 32'hFFFF_FFFF; #1;
      chk("wr_busy", busy === (i < 5), busy, (i < 5));
      chk("wr_rw", bus_rw === 1'b0, bus_rw, 1'b0);
      chk("wr_wdata", bus_wr_data === 32'h1234_5678, bus_wr_data, 32'h1234_5678);
      chk("wr_as", bus_as_ === (i != 1), bus_as_, (i != 1));
    end
    chk("wr_done_rdata", rd_data === 32'h0, rd_data, 32'h0);
    nxt(); as_ = 1'b1; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; #1;
    chk("wr_after_req", bus_req_ === 1'b1, bus_req_, 1'b1);

    // 3: read completes with stall held, new access waits for IDLE
    nxt(); as_ = 1'b0; rw = 1'b1; addr = 30'h300; bus_grnt_ = 1'b0; #1;
    chk("st_accept_busy", busy === 1'b1, busy, 1'b1);
    nxt(); #1;
    nxt(); #1;
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5_0001; stall = 1'b1; #1;
    chk("st_done_busy", busy === 1'b0, busy, 1'b0);
    chk("st_done_data", rd_data === 32'hA5A5_0001, rd_data, 32'hA5A5_0001);
    for (int k = 0; k < 3; k++) begin
      nxt(); stall = (k < 2); as_ = 1'b0; addr = 30'h400; rw = 1'b1;
      bus_rdy_ = 1'b1; bus_rd_data = 32'h0; #1;
      chk("st_hold_data", rd_data === 32'hA5A5_0001, rd_data, 32'hA5A5_0001);
      chk("st_hold_busy", busy === 1'b0, busy, 1'b0);
      chk("st_hold_req", bus_req_ === 1'b1, bus_req_, 1'b1);
    end
    nxt(); #1;
    chk("st_new_accept", busy === 1'b1, busy, 1'b1);
    nxt(); #1;
    chk("st_new_req", bus_req_ === 1'b0, bus_req_, 1'b0);
    chk("st_new_addr", bus_addr === 30'h400, bus_addr, 30'h400);
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'h0000_0055; #1;
    chk("acc_rdy_as", bus_as_ === 1'b0, bus_as_, 1'b0);
    chk("acc_rdy_busy", busy === 1'b0, busy, 1'b0);
    chk("acc_rdy_data", rd_data === 32'h0000_0055, rd_data, 32'h0000_0055);
    nxt(); as_ = 1'b1; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; #1;
    chk("acc_after_req", bus_req_ === 1'b1, bus_req_, 1'b1);
    chk("acc_after_as", bus_as_ === 1'b1, bus_as_, 1'b1);

    // 4: timeout with slave never ready
    nxt(); as_ = 1'b0; rw = 1'b1; addr = 30'h500; bus_grnt_ = 1'b0; bus_rd_data = 32'h1111_1111; #1;
    chk("to_accept_busy", busy === 1'b1, busy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      nxt(); #1;
      chk("to_busy", busy === (i < 5), busy, (i < 5));
      chk("to_err_low", bus_err === 1'b0, bus_err, 1'b0);
      chk("to_rdata", rd_data === 32'h0, rd_data, 32'h0);
    end
    nxt(); as_ = 1'b1; bus_grnt_ = 1'b1; #1;
    chk("to_err_pulse", bus_err === 1'b1, bus_err, 1'b1);
    chk("to_req", bus_req_ === 1'b1, bus_req_, 1'b1);
    chk("to_idle_busy", busy === 1'b0, busy, 1'b0);
    nxt(); #1;
    chk("to_err_clear", bus_err === 1'b0, bus_err, 1'b0);

    // 5: flush suppresses acceptance; long ungranted request never times out
    for (int i = 0; i < 3; i++) begin
      nxt(); as_ = 1'b0; flush = 1'b1; addr = 30'h600; #1;
      chk("fl_busy", busy === 1'b0, busy, 1'b0);
      chk("fl_req", bus_req_ === 1'b1, bus_req_, 1'b1);
    end
    nxt(); flush = 1'b0; #1;
    chk("arb_accept_busy", busy === 1'b1, busy, 1'b1);
    for (int i = 0; i < 50; i++) begin
      nxt(); #1;
      chk("arb_wait", {busy, bus_as_, bus_err, bus_req_} === 4'b1100,
          {busy, bus_as_, bus_err, bus_req_}, 4'b1100);
    end
    nxt(); bus_grnt_ = 1'b0; #1;
    nxt(); bus_grnt_ = 1'b1; #1;
    chk("arb_access_as", bus_as_ === 1'b0, bus_as_, 1'b0);
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'h0000_0077; #1;
    chk("arb_done_data", rd_data === 32'h0000_0077, rd_data, 32'h0000_0077);
    chk("arb_done_busy", busy === 1'b0, busy, 1'b0);
    nxt(); as_ = 1'b1; bus_rdy_ = 1'b1; #1;
    chk("arb_after_err", bus_err === 1'b0, bus_err, 1'b0);

    // 6: async reset in the middle of WAIT
    nxt(); as_ = 1'b0; rw = 1'b1; addr = 30'h6A0; bus_grnt_ = 1'b0; #1;
    nxt(); #1;
    nxt(); #1;
    nxt(); #1;
    chk("ar_wait_busy", busy === 1'b1, busy, 1'b1);
    chk("ar_wait_req", bus_req_ === 1'b0, bus_req_, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("ar_req", bus_req_ === 1'b1, bus_req_, 1'b1);
    chk("ar_as", bus_as_ === 1'b1, bus_as_, 1'b1);
    chk("ar_busy", busy === 1'b0, busy, 1'b0);
    chk("ar_addr", bus_addr === 30'h0, bus_addr, 30'h0);
    nxt(); reset = 1'b1; addr = 30'h700; #1;
    chk("ar_new_accept", busy === 1'b1, busy, 1'b1);
    nxt(); #1;
    chk("ar_new_addr", bus_addr === 30'h700, bus_addr, 30'h700);
    nxt(); #1;
    nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D; #1;
    chk("ar_new_data", rd_data === 32'hCAFE_F00D, rd_data, 32'hCAFE_F00D);
    chk("ar_new_busy", busy === 1'b0, busy, 1'b0);
    nxt(); as_ = 1'b1; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; #1;
    chk("ar_new_req", bus_req_ === 1'b1, bus_req_, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
